fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. Holds the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register for decode. Supports decode-side stalls, taken-branch redirect and flush, and keeps a saturating count of fetched instructions. It sits directly upstream of instruction memory (address) and directly upstream of decode (IF/ID register).

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, instruction-memory address, IF/ID register, fetch counter.
// Optional FETCH_DELAY_SLOT_EN: branches keep the delay-slot fetch instead of squashing it.
module fetch_stage #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic [7:0]  i_address,
    input  logic [31:0] instruction,
    output logic [31:0] if_id_instr,
    output logic [7:0]  if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [15:0] fetch_count
);

    logic [7:0]  pc;
    logic [7:0]  pc_plus4;
    logic [7:0]  target;
    logic [15:0] count_inc;

    assign i_address = pc;
    assign pc_plus4  = pc + 8'd4;
    assign target    = {branch_target[7:2], 2'b00};

    always_comb begin
        count_inc = fetch_count;
        if (fetch_count != 16'hFFFF) begin
            count_inc = fetch_count + 16'd1;
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [0:0] state;
    logic [7:0] pend_target;
    logic [7:0] redirect;

    // A branch arriving while already pending replaces the stored target.
    assign redirect = branch_taken ? target : pend_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
            state          <= RUN;
            pend_target    <= '0;
        end else if (state == PEND || branch_taken) begin
            if (!stall) begin
                pc             <= (state == PEND) ? redirect : target;
                if_id_instr    <= instruction;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
                fetch_count    <= count_inc;
                state          <= RUN;
            end else begin
                pend_target <= redirect;
                state       <= PEND;
            end
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_instr    <= instruction;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            fetch_count    <= count_inc;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
        end else if (branch_taken) begin
            // Redirect overrides stall; instr/pc_plus4 hold under the squashed valid.
            pc          <= target;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_instr    <= instruction;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            fetch_count    <= count_inc;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; covers both FETCH_DELAY_SLOT_EN builds.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  i_address;
    logic [31:0] instruction;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc_plus4;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(8'h00)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .i_address      (i_address),
        .instruction    (instruction),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [7:0] a);
        if (a == 8'h00) return 32'h21080003;
        return {8'hA5, a, ~a, a};
    endfunction

    assign instruction = mem(i_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic br, input logic [7:0] tgt);
        reset = rst; stall = stl; branch_taken = br; branch_target = tgt;
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    endtask

    task automatic check_ifid(input string tag, input logic [7:0] pc, input logic [31:0] instr,
                              input logic [7:0] p4, input logic v, input logic [15:0] cnt);
        check({tag, ".addr"},  {24'h0, i_address},      {24'h0, pc});
        check({tag, ".instr"}, if_id_instr,             instr);
        check({tag, ".pc4"},   {24'h0, if_id_pc_plus4}, {24'h0, p4});
        check({tag, ".valid"}, {31'h0, if_id_valid},    {31'h0, v});
        check({tag, ".count"}, {16'h0, fetch_count},    {16'h0, cnt});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_ifid("reset", 8'h00, 32'h0, 8'h00, 1'b0, 16'd0);

        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("first", 8'h04, 32'h21080003, 8'h04, 1'b1, 16'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("second", 8'h08, mem(8'h04), 8'h08, 1'b1, 16'd2);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            check_ifid("stall", 8'h08, mem(8'h04), 8'h08, 1'b1, 16'd2);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("unstall", 8'h0C, mem(8'h08), 8'h0C, 1'b1, 16'd3);

`ifdef FETCH_DELAY_SLOT_EN
        step(1'b0, 1'b0, 1'b1, 8'h31);
        check_ifid("br_slot", 8'h30, mem(8'h0C), 8'h10, 1'b1, 16'd4);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("at_tgt", 8'h34, mem(8'h30), 8'h34, 1'b1, 16'd5);
        step(1'b0, 1'b1, 1'b1, 8'h52);
        check_ifid("pend", 8'h34, mem(8'h30), 8'h34, 1'b1, 16'd5);
        step(1'b0, 1'b1, 1'b1, 8'h61);
        check_ifid("pend_ovr", 8'h34, mem(8'h30), 8'h34, 1'b1, 16'd5);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("pend_done", 8'h60, mem(8'h34), 8'h38, 1'b1, 16'd6);
        step(1'b0, 1'b0, 1'b1, 8'hFE);
        check_ifid("to_fc", 8'hFC, mem(8'h60), 8'h64, 1'b1, 16'd7);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("wrap", 8'h00, mem(8'hFC), 8'h00, 1'b1, 16'd8);
        step(1'b0, 1'b1, 1'b1, 8'h40);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_ifid("rst_pend", 8'h00, 32'h0, 8'h00, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("rst_pend_run", 8'h04, 32'h21080003, 8'h04, 1'b1, 16'd1);
`else
        step(1'b0, 1'b0, 1'b1, 8'h31);
        check_ifid("br_squash", 8'h30, mem(8'h08), 8'h0C, 1'b0, 16'd3);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("at_tgt", 8'h34, mem(8'h30), 8'h34, 1'b1, 16'd4);
        step(1'b0, 1'b1, 1'b1, 8'h52);
        check_ifid("br_stall", 8'h50, mem(8'h30), 8'h34, 1'b0, 16'd4);
        step(1'b0, 1'b0, 1'b1, 8'hFE);
        check_ifid("to_fc", 8'hFC, mem(8'h30), 8'h34, 1'b0, 16'd4);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_ifid("wrap", 8'h00, mem(8'hFC), 8'h00, 1'b1, 16'd5);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_ifid("rst_stall", 8'h00, 32'h0, 8'h00, 1'b0, 16'd0);
`endif

        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 65534; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end
        check("sat_fffe", {16'h0, fetch_count}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end
        check("sat_ffff", {16'h0, fetch_count}, 32'h0000FFFF);
        check("sat_valid", {31'h0, if_id_valid}, 32'h1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("sat_reset", {16'h0, fetch_count}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
